// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the DA FIR control path: sequencer state encoding
// and the address/channel width helpers used by the sequencer and DA engine bench.
package fir_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ARMED = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4
    } fir_state_e;

    function automatic int calc_caw(input int coef_words);
        return (coef_words > 1) ? $clog2(coef_words) : 1;
    endfunction

    function automatic int calc_chw(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// DA_LAT-stage shift register carrying {valid, channel} alongside the DA engine
// so results come out latency-matched; synchronous reset flushes every stage.
module valid_delay_line #(
    parameter int DA_LAT = 4,
    parameter int CHW    = 1
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           in_valid,
    input  logic [CHW-1:0] in_ch,
    output logic           out_valid,
    output logic [CHW-1:0] out_ch,
    output logic           any_valid
);

    logic [DA_LAT-1:0] vld_q, vld_d;
    logic [CHW-1:0]    ch_q [DA_LAT];
    logic [CHW-1:0]    ch_d [DA_LAT];

    always_comb begin
        vld_d = DA_LAT'({vld_q, in_valid});
        ch_d[0] = in_ch;
        for (int i = 1; i < DA_LAT; i++) begin
            ch_d[i] = ch_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_q <= '0;
            for (int i = 0; i < DA_LAT; i++) begin
                ch_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            ch_q  <= ch_d;
        end
    end

    assign out_valid = vld_q[DA_LAT-1];
    assign out_ch    = ch_q[DA_LAT-1];
    assign any_valid = |vld_q;

endmodule

// File: rtl/fir_da_sequencer.sv
// Control sequencer for the DA FIR datapath: coefficient load, round-robin
// channel interleave, stop/drain. Define FIR_SEQ_RELOAD_EN to allow cload during a run.
module fir_da_sequencer
    import fir_ctrl_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int COEF_WORDS = 16,
    parameter int DA_LAT     = 4
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              cload,
    input  logic                              coef_valid,
    output logic                              coef_ready,
    output logic                              coef_we,
    output logic [calc_caw(COEF_WORDS)-1:0]   coef_addr,
    input  logic                              valid_in,
    output logic                              in_ready,
    input  logic                              stop,
    output logic                              enable_fifo,
    output logic                              resetn_fifo,
    output logic                              resetn_da,
    output logic                              start_da,
    output logic                              valid_out,
    output logic [calc_chw(NUM_CH)-1:0]       ch_out,
    output logic                              busy,
    output logic [2:0]                        state_o
);

    localparam int CAW = calc_caw(COEF_WORDS);
    localparam int CHW = calc_chw(NUM_CH);
    localparam int IFW = $clog2(DA_LAT + 1);

    fir_state_e     state_q, state_d;
    logic [CAW-1:0] coef_cnt_q, coef_cnt_d;
    logic [CHW-1:0] ch_cnt_q, ch_cnt_d;
    logic [IFW-1:0] inflight_q, inflight_d;
    logic           accept;
    logic           pipe_busy;
`ifdef FIR_SEQ_RELOAD_EN
    logic           reload_pending_q, reload_pending_d;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            coef_cnt_q <= '0;
            ch_cnt_q   <= '0;
            inflight_q <= '0;
`ifdef FIR_SEQ_RELOAD_EN
            reload_pending_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            coef_cnt_q <= coef_cnt_d;
            ch_cnt_q   <= ch_cnt_d;
            inflight_q <= inflight_d;
`ifdef FIR_SEQ_RELOAD_EN
            reload_pending_q <= reload_pending_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        coef_cnt_d  = coef_cnt_q;
        ch_cnt_d    = ch_cnt_q;
        inflight_d  = inflight_q;
        coef_ready  = 1'b0;
        coef_we     = 1'b0;
        in_ready    = 1'b0;
        resetn_fifo = 1'b0;
        resetn_da   = 1'b0;
`ifdef FIR_SEQ_RELOAD_EN
        reload_pending_d = reload_pending_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cload) begin
                    state_d    = ST_LOAD;
                    coef_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                resetn_da  = 1'b1;
                coef_ready = 1'b1;
                coef_we    = coef_valid;
                if (coef_valid) begin
                    coef_cnt_d = coef_cnt_q + CAW'(1);
                    if (coef_cnt_q == CAW'(COEF_WORDS - 1)) begin
                        state_d  = ST_ARMED;
                        ch_cnt_d = '0;
                    end
                end
            end
            ST_ARMED, ST_RUN: begin
                resetn_da   = 1'b1;
                resetn_fifo = 1'b1;
                in_ready    = 1'b1;
                // stop outranks a reload request raised in the same cycle
                if (stop) begin
                    state_d = ST_DRAIN;
`ifdef FIR_SEQ_RELOAD_EN
                    reload_pending_d = 1'b0;
                end else if (cload) begin
                    state_d          = ST_DRAIN;
                    reload_pending_d = 1'b1;
`endif
                end else if (state_q == ST_ARMED && valid_in) begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                resetn_da   = 1'b1;
                resetn_fifo = 1'b1;
                if (inflight_q == '0 && !pipe_busy) begin
`ifdef FIR_SEQ_RELOAD_EN
                    if (reload_pending_q) begin
                        state_d          = ST_LOAD;
                        coef_cnt_d       = '0;
                        reload_pending_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        accept = valid_in & in_ready;
        if (accept) begin
            ch_cnt_d = (ch_cnt_q == CHW'(NUM_CH - 1)) ? '0 : ch_cnt_q + CHW'(1);
        end

        case ({accept, valid_out})
            2'b10:   inflight_d = inflight_q + IFW'(1);
            2'b01:   inflight_d = inflight_q - IFW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    valid_delay_line #(
        .DA_LAT (DA_LAT),
        .CHW    (CHW)
    ) u_vdl (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (accept),
        .in_ch     (ch_cnt_q),
        .out_valid (valid_out),
        .out_ch    (ch_out),
        .any_valid (pipe_busy)
    );

    assign enable_fifo = accept;
    assign start_da    = accept;
    assign coef_addr   = (state_q == ST_LOAD) ? coef_cnt_q : '0;
    assign busy        = (state_q != ST_IDLE);
    assign state_o     = state_q;

endmodule
